// File: rtl/prm_obstacle_scan.sv
// Drives occupied-voxel indices onto the shared obstacle-checker bus and OR-accumulates
// the returned per-edge hit vectors into a blocked-edge mask for roadmap pruning.
module prm_obstacle_scan #(
    parameter int NUM_EDGES = 16,
    parameter int IDX_W     = 15,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic                 vox_valid,
    output logic                 vox_ready,
    input  logic [IDX_W-1:0]     vox_idx,
    input  logic                 vox_last,
    output logic [IDX_W-1:0]     chk_idx,
    input  logic [NUM_EDGES-1:0] chk_hit,
    output logic [NUM_EDGES-1:0] blocked_mask,
    output logic [CNT_W-1:0]     vox_count,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_reg, state_next;
    logic                   v1_reg, v2_reg;
    logic [NUM_EDGES-1:0]   hit_reg;
    logic [NUM_EDGES-1:0]   mask_next;
    logic                   xfer;
    logic                   clear;

    assign xfer  = vox_valid & vox_ready;
    assign clear = start & ((state_reg == IDLE) | (state_reg == DONE));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (xfer && vox_last) state_next = DRAIN;
            DRAIN:   if (!v1_reg && !v2_reg) state_next = DONE;
            DONE:    state_next = start ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vox_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            SCAN:    begin vox_ready = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Issue stage: chk_idx only moves on a real transfer so the checker bus stays quiet.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            chk_idx <= '0;
            v1_reg  <= 1'b0;
        end else begin
            v1_reg <= xfer;
            if (xfer) chk_idx <= vox_idx;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_reg <= '0;
            v2_reg  <= 1'b0;
        end else begin
            v2_reg <= v1_reg;
            if (v1_reg) hit_reg <= chk_hit;
        end
    end

    for (genvar gi = 0; gi < NUM_EDGES; gi++) begin : g_acc
        assign mask_next[gi] = clear ? 1'b0 : (blocked_mask[gi] | (v2_reg & hit_reg[gi]));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) blocked_mask <= '0;
        else     blocked_mask <= mask_next;
    end

    // A transfer can never coincide with clear: vox_ready is low in IDLE and DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                              vox_count <= '0;
        else if (clear)                       vox_count <= '0;
        else if (xfer && vox_count != CNT_MAX) vox_count <= vox_count + 1'b1;
    end

endmodule

// File: tb/tb_prm_obstacle_scan.sv
// Scoreboard bench: the driver pushes per-frame expectations from a behavioural model,
// a negedge monitor compares them whenever done is presented.
module tb_prm_obstacle_scan;
    localparam int NE = 16;
    localparam int IW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          vox_valid = 1'b0;
    logic          vox_last = 1'b0;
    logic [IW-1:0] vox_idx = '0;

    logic          vox_ready, busy, done;
    logic [IW-1:0] chk_idx;
    logic [NE-1:0] chk_hit, blocked_mask;
    logic [15:0]   vox_count;

    logic          vox_ready4, busy4, done4;
    logic [IW-1:0] chk_idx4;
    logic [NE-1:0] chk_hit4, blocked_mask4;
    logic [3:0]    vox_count4;

    always #5 clk = ~clk;

    // Checker bank model: indices with top bits 11 block one edge, 15'h4000 blocks edges 0 and 2.
    function automatic logic [NE-1:0] hit_fn(input logic [IW-1:0] idx);
        if (idx[14:13] == 2'b11) return 16'h0001 << idx[3:0];
        if (idx == 15'h4000)     return 16'h0005;
        return 16'h0000;
    endfunction

    assign chk_hit  = hit_fn(chk_idx);
    assign chk_hit4 = hit_fn(chk_idx4);

    prm_obstacle_scan #(.NUM_EDGES(NE), .IDX_W(IW), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .start(start), .vox_valid(vox_valid), .vox_ready(vox_ready),
        .vox_idx(vox_idx), .vox_last(vox_last), .chk_idx(chk_idx), .chk_hit(chk_hit),
        .blocked_mask(blocked_mask), .vox_count(vox_count), .busy(busy), .done(done)
    );

    prm_obstacle_scan #(.NUM_EDGES(NE), .IDX_W(IW), .CNT_W(4)) dut4 (
        .CLK(clk), .RST(rst), .start(start), .vox_valid(vox_valid), .vox_ready(vox_ready4),
        .vox_idx(vox_idx), .vox_last(vox_last), .chk_idx(chk_idx4), .chk_hit(chk_hit4),
        .blocked_mask(blocked_mask4), .vox_count(vox_count4), .busy(busy4), .done(done4)
    );

    typedef struct packed {
        logic [NE-1:0] mask;
        logic [15:0]   cnt;
        logic [3:0]    cnt4;
    } exp_t;

    exp_t sb[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   frame_no = 0;
    bit   streaming = 1'b0;
    bit   finish_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [IW-1:0] exp_chk = '0;
    int            done_due = -1;
    logic          prev_done = 1'b0;
    logic          prev_start = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("rst_vox_ready", {31'd0, vox_ready}, 32'd0);
            chk("rst_chk_idx", {17'd0, chk_idx}, 32'd0);
            chk("rst_blocked_mask", {16'd0, blocked_mask}, 32'd0);
            chk("rst_vox_count", {16'd0, vox_count}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            exp_chk    = '0;
            done_due   = -1;
            prev_done  = 1'b0;
            prev_start = 1'b0;
        end else begin
            chk("chk_idx_hold", {17'd0, chk_idx}, {17'd0, exp_chk});
            chk("done4_align", {31'd0, done4}, {31'd0, done});
            if (streaming) begin
                chk("no_bubble_ready", {31'd0, vox_ready}, 32'd1);
                chk("scan_busy", {31'd0, busy}, 32'd1);
            end
            if (prev_done) chk("done_width", {31'd0, done}, 32'd0);
            if (prev_done && prev_start) begin
                chk("restart_mask", {16'd0, blocked_mask}, 32'd0);
                chk("restart_count", {16'd0, vox_count}, 32'd0);
                chk("restart_ready", {31'd0, vox_ready}, 32'd1);
            end
            if (done) begin
                chk("done_latency", cyc, done_due);
                chk("done_busy", {31'd0, busy}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done");
                end else begin
                    e = sb.pop_front();
                    $display("frame %0d: mask=%04h count=%0d count4=%0d", frame_no, blocked_mask, vox_count, vox_count4);
                    frame_no++;
                    chk("blocked_mask", {16'd0, blocked_mask}, {16'd0, e.mask});
                    chk("vox_count", {16'd0, vox_count}, {16'd0, e.cnt});
                    chk("blocked_mask_cnt4", {16'd0, blocked_mask4}, {16'd0, e.mask});
                    chk("vox_count_sat4", {28'd0, vox_count4}, {28'd0, e.cnt4});
                end
            end
            if (vox_valid && vox_ready) begin
                exp_chk = vox_idx;
                if (vox_last) done_due = cyc + 4;
            end
            prev_done  = done;
            prev_start = start;
        end
        if (finish_req) begin
            chk("scoreboard_empty", sb.size(), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: random index; 1: back-to-back set with hits only at voxels 10/50/90; 2: 15'h4000.
    task automatic stream(input int n, input int mode, input bit stall, input int start_at);
        logic [NE-1:0] m;
        logic [IW-1:0] idx;
        int            acc;
        bit            v;
        exp_t          e;
        m   = '0;
        acc = 0;
        streaming = 1'b1;
        while (acc < n) begin
            v = stall ? bit'($urandom_range(0, 1)) : 1'b1;
            case (mode)
                1: begin
                    idx = {1'b0, 14'($urandom)};
                    if (acc == 10) idx = {2'b11, 9'($urandom), 4'd0};
                    if (acc == 50) idx = {2'b11, 9'($urandom), 4'd3};
                    if (acc == 90) idx = {2'b11, 9'($urandom), 4'd15};
                end
                2:       idx = 15'h4000;
                default: idx = 15'($urandom_range(0, 32767));
            endcase
            vox_valid = v;
            vox_idx   = v ? idx : 15'($urandom);
            vox_last  = v && (acc == n - 1);
            start     = (acc == start_at);
            tick();
            if (v) begin
                m |= hit_fn(idx);
                acc++;
            end
        end
        streaming = 1'b0;
        vox_valid = 1'b0;
        vox_last  = 1'b0;
        start     = 1'b0;
        e.mask = m;
        e.cnt  = 16'(n);
        e.cnt4 = (n > 15) ? 4'd15 : 4'(n);
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done) begin
            tick();
            t++;
            if (t > 50) begin
                $display("FAIL wait_done actual=timeout required=done_pulse");
                $fatal(1, "done never asserted");
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Abort a scan after three hitting voxels; the following frame must show no residue.
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            vox_valid = 1'b1;
            vox_idx   = {2'b11, 9'($urandom), 4'($urandom)};
            tick();
        end
        vox_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        pulse_start(); stream(1, 2, 1'b0, -1);   wait_done(); tick();
        pulse_start(); stream(100, 1, 1'b0, -1); wait_done(); tick();
        pulse_start(); stream(20, 0, 1'b1, 5);   wait_done(); tick();

        // start held in the DONE cycle goes straight back to SCAN.
        pulse_start(); stream(20, 0, 1'b0, -1);  wait_done();
        pulse_start(); stream(10, 0, 1'b1, -1);  wait_done(); tick();

        for (int f = 0; f < 6; f++) begin
            pulse_start();
            stream($urandom_range(1, 40), 0, bit'($urandom_range(0, 1)), -1);
            wait_done();
            tick();
        end

        repeat (3) tick();
        finish_req = 1'b1;
    end
endmodule
